// File: rtl/lc3b_types.sv
// Shared LC-3b types: the machine word and the memory-port arbiter state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } mem_arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the IF fetch path and the MEM stage.
// Latency: one edge from request to pmem strobe; the pmem_resp cycle returns to IDLE,
//   so back-to-back grants are two cycles apart.
// Backpressure: a requester waits (no resp) until granted and pmem_resp arrives; MEM has
//   fixed priority unless ARB_STARVE_GUARD_EN is defined, which forces an IF win after
//   STARVE_LIMIT consecutive MEM grants taken while IF was waiting.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  lc3b_word       if_memaddr,
  input  logic           if_memread,
  output logic           if_mem_resp,
  output logic [15:0]    if_mem_rdata,
  input  logic [15:0]    mem_address,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     mem_byte_enable,
  input  logic [15:0]    mem_wdata,
  output logic           mem_resp,
  output logic [15:0]    mem_rdata,
  output logic [15:0]    pmem_address,
  output logic           pmem_read,
  output logic           pmem_write,
  output logic [1:0]     pmem_byte_enable,
  output logic [15:0]    pmem_wdata,
  input  logic           pmem_resp,
  input  logic [15:0]    pmem_rdata
);

  // A zero limit would make the guard fire on the very first conflict.
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  mem_arb_state_t r_state;
  mem_arb_state_t w_state_nxt;

  logic           w_mem_req;
  logic           w_if_force;
  logic           w_grant_if;
  logic           w_grant_mem;
  logic           w_done;

  // Captured transaction; these registers drive the pmem port directly so it
  // stays glitch-free and ignores requester changes after the grant.
  logic [15:0]    r_addr;
  logic           r_read;
  logic           r_write;
  logic [1:0]     r_be;
  logic [15:0]    r_wdata;

  assign w_mem_req = mem_read | mem_write;
  assign w_done    = (r_state != IDLE) && pmem_resp;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_if_force = if_memread && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count MEM wins that left IF waiting; any IF win clears the debt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_mem && if_memread &&
                 (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_if_force = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant decision in IDLE; hold a SERVE state until the port completes.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_req && !w_if_force) begin
          w_state_nxt = SERVE_MEM;
          w_grant_mem = 1'b1;
        end else if (if_memread) begin
          w_state_nxt = SERVE_IF;
          w_grant_if  = 1'b1;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (pmem_resp) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the winner's request on grant; clear back to zero when it completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_grant_mem) begin
      r_addr  <= mem_address;
      r_read  <= !mem_write;   // read+write together is a write
      r_write <= mem_write;
      r_be    <= mem_byte_enable;
      r_wdata <= mem_wdata;
    end else if (w_grant_if) begin
      r_addr  <= if_memaddr;
      r_read  <= 1'b1;
      r_write <= 1'b0;
      r_be    <= 2'b11;
      r_wdata <= '0;
    end else if (w_done) begin
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end
  end

  assign pmem_address     = r_addr;
  assign pmem_read        = r_read;
  assign pmem_write       = r_write;
  assign pmem_byte_enable = r_be;
  assign pmem_wdata       = r_wdata;

  // Completion is steered to whichever requester owns the port this cycle.
  assign if_mem_resp  = pmem_resp && (r_state == SERVE_IF);
  assign mem_resp     = pmem_resp && (r_state == SERVE_MEM);
  assign if_mem_rdata = pmem_rdata;
  assign mem_rdata    = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (owner + captured request, priority rule).
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] if_memaddr = '0;
  logic        if_memread = 1'b0;
  logic        if_mem_resp;
  logic [15:0] if_mem_rdata;
  logic [15:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_byte_enable = '0;
  logic [15:0] mem_wdata = '0;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic [15:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_wdata;
  logic        pmem_resp = 1'b0;
  logic [15:0] pmem_rdata = '0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_memaddr(if_memaddr), .if_memread(if_memread),
    .if_mem_resp(if_mem_resp), .if_mem_rdata(if_mem_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: is the port busy, who owns it, and what was captured.
  bit          m_busy;
  bit          m_owner_mem;
  bit          m_wr;
  logic [15:0] m_addr;
  logic [1:0]  m_be;
  logic [15:0] m_wdata;
  int          m_debt;

  // Per-scenario observation counters and resp owner log (1 = MEM, 0 = IF).
  int n_rd, n_ifresp, n_memresp;
  int q_own[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_mem = 0; m_wr = 0;
    m_addr = '0; m_be = '0; m_wdata = '0; m_debt = 0;
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are checked
  // on the falling edge, then the model advances as the next rising edge will.
  task automatic step();
    bit mreq, ireq, take_if, take_mem;
    @(negedge clk);
    #1;
    check("pmem_read",  pmem_read,  m_busy && !m_wr);
    check("pmem_write", pmem_write, m_busy && m_wr);
    check("pmem_addr",  pmem_address, m_busy ? m_addr : 16'h0);
    check("pmem_be",    pmem_byte_enable, m_busy ? m_be : 2'b00);
    check("pmem_wdata", pmem_wdata, m_busy ? m_wdata : 16'h0);
    check("if_resp",    if_mem_resp, m_busy && !m_owner_mem && pmem_resp);
    check("mem_resp",   mem_resp, m_busy && m_owner_mem && pmem_resp);
    check("if_rdata",   if_mem_rdata, pmem_rdata);
    check("mem_rdata",  mem_rdata, pmem_rdata);
    if (pmem_read) n_rd++;
    if (if_mem_resp) begin n_ifresp++; q_own.push_back(0); end
    if (mem_resp) begin n_memresp++; q_own.push_back(1); end

    if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else begin
      mreq = mem_read || mem_write;
      ireq = if_memread;
`ifdef ARB_STARVE_GUARD_EN
      take_if = ireq && (!mreq || m_debt == LIMIT);
`else
      take_if = ireq && !mreq;
`endif
      take_mem = mreq && !take_if;
      if (take_mem) begin
        m_busy = 1; m_owner_mem = 1; m_wr = mem_write;
        m_addr = mem_address; m_be = mem_byte_enable; m_wdata = mem_wdata;
        if (ireq && m_debt < LIMIT) m_debt++;
      end else if (take_if) begin
        m_busy = 1; m_owner_mem = 0; m_wr = 0;
        m_addr = if_memaddr; m_be = 2'b11; m_wdata = 16'h0;
        m_debt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    if_memread = 0; mem_read = 0; mem_write = 0; pmem_resp = 0;
  endtask

  // Asserts reset mid-cycle and checks the outputs clear without waiting for an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pmem_read",  pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr",  pmem_address, 16'h0);
    check("rst_pmem_be",    pmem_byte_enable, 2'b00);
    check("rst_pmem_wdata", pmem_wdata, 16'h0);
    check("rst_if_resp",    if_mem_resp, 1'b0);
    check("rst_mem_resp",   mem_resp, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    n_rd = 0; n_ifresp = 0; n_memresp = 0;
    q_own.delete();
  endtask

  initial begin
    model_reset();
    #2;
    pmem_resp = 1'b1;
    do_reset();
    set_idle_inputs();
    step();
    step();

    // IF-only read at 0x3000, completion on the third serve cycle.
    clear_counts();
    if_memread = 1; if_memaddr = 16'h3000;
    step();
    if_memread = 0;
    step();
    step();
    pmem_resp = 1; pmem_rdata = 16'h1234;
    check("if_rdata_1234", if_mem_rdata, 16'h1234);
    step();
    pmem_resp = 0;
    step();
    check("if_read_cycles", n_rd, 3);
    check("if_resp_pulses", n_ifresp, 1);
    check("if_no_mem_resp", n_memresp, 0);

    // MEM write 0xABCD to 0x4002, low byte only.
    clear_counts();
    mem_write = 1; mem_address = 16'h4002; mem_byte_enable = 2'b01; mem_wdata = 16'hABCD;
    step();
    mem_write = 0; mem_address = 16'h0; mem_wdata = 16'h0;
    for (int i = 0; i < 3; i++) begin
      check("wr_strobe", pmem_write, 1'b1);
      check("wr_be",     pmem_byte_enable, 2'b01);
      check("wr_data",   pmem_wdata, 16'hABCD);
      if (i == 2) pmem_resp = 1;
      step();
    end
    pmem_resp = 0;
    step();
    check("wr_resp_pulses", n_memresp, 1);

    // Conflict: MEM wins, IF follows on the second edge after MEM's resp.
    clear_counts();
    if_memread = 1; if_memaddr = 16'h3100;
    mem_read = 1; mem_address = 16'h5000; mem_byte_enable = 2'b11;
    step();
    check("conf_mem_first", pmem_address, 16'h5000);
    pmem_resp = 1;
    step();
    mem_read = 0; pmem_resp = 0;
    check("conf_gap_idle", pmem_read, 1'b0);
    step();
    check("conf_if_second", pmem_address, 16'h3100);
    if_memread = 0; pmem_resp = 1;
    step();
    pmem_resp = 0;
    step();
    check("conf_order_n", q_own.size(), 2);
    if (q_own.size() == 2) begin
      check("conf_order_0", q_own[0], 1);
      check("conf_order_1", q_own[1], 0);
    end

    // Address moves mid-serve, then reset abandons the transaction.
    clear_counts();
    if_memread = 1; if_memaddr = 16'h3200;
    step();
    if_memaddr = 16'h7777;
    step();
    check("hold_addr", pmem_address, 16'h3200);
    check("pre_rst_read", pmem_read, 1'b1);
    pmem_resp = 1;
    if_memread = 0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    pmem_resp = 0;
    check("no_resp_after_rst", n_ifresp + n_memresp, 0);

    // Both requesting continuously with instant completion: grant order.
    do_reset();
    clear_counts();
    if_memread = 1; if_memaddr = 16'h3300;
    mem_read = 1; mem_address = 16'h6000; pmem_resp = 1;
    for (int i = 0; i < 24; i++) step();
    set_idle_inputs();
    step();
    check("order_len", q_own.size() >= 10, 1'b1);
    for (int i = 0; i < 10 && i < q_own.size(); i++) begin
`ifdef ARB_STARVE_GUARD_EN
      check($sformatf("order_%0d", i), q_own[i], (i % (LIMIT + 1) == LIMIT) ? 0 : 1);
`else
      check($sformatf("order_%0d", i), q_own[i], 1);
`endif
    end

    // Randomized traffic, including drops mid-transaction, stray resp in IDLE
    // and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        pmem_resp = $urandom_range(0, 1);
        do_reset();
      end
      if_memread      = ($urandom_range(0, 99) < 45);
      if_memaddr      = 16'($urandom);
      mem_read        = ($urandom_range(0, 99) < 35);
      mem_write       = ($urandom_range(0, 99) < 25);
      mem_address     = 16'($urandom);
      mem_byte_enable = 2'($urandom);
      mem_wdata       = 16'($urandom);
      pmem_resp       = ($urandom_range(0, 2) == 0);
      pmem_rdata      = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win (used only with ARB_STARVE_GUARD_EN).
REQ-002 SHALL have ports, one per line:
 clk  input  1  system clock, rising edge
 rst  input  1  asynchronous, active-high reset
 if_memaddr  input  16 (lc3b_word)  IF fetch address
 if_memread  input  1  IF read request
 if_mem_resp  output  1  IF transaction done
 if_mem_rdata  output  16  IF read data
 mem_address  input  16  MEM-stage address
 mem_read  input  1  MEM-stage read request
 mem_write  input  1  MEM-stage write request
 mem_byte_enable  input  2  MEM-stage byte enables
 mem_wdata  input  16  MEM-stage write data
 mem_resp  output  1  MEM-stage transaction done
 mem_rdata  output  16  MEM-stage read data
 pmem_address  output  16  shared-port address
 pmem_read  output  1  shared-port read strobe
 pmem_write  output  1  shared-port write strobe
 pmem_byte_enable  output  2  shared-port byte enables
 pmem_wdata  output  16  shared-port write data
 pmem_resp  input  1  shared-port completion
 pmem_rdata  input  16  shared-port read data
REQ-003 Clock port SHALL be clk and reset port rst; one clock; rst asynchronous, active-high.

Function
REQ-004 SHALL implement FSM states IDLE, SERVE_IF, SERVE_MEM.
REQ-005 In IDLE, at a rising edge with a pending request, SHALL move to SERVE_MEM if (mem_read|mem_write), else SERVE_IF if if_memread; otherwise remain in IDLE.
REQ-006 On grant, SHALL register address, byte enables, wdata and read/write kind; IF grants register byte enable 2'b11, write 0.
REQ-007 pmem_* outputs SHALL be driven from registered values only, held constant for the whole SERVE state, and equal zero in IDLE.
REQ-008 SHALL remain in SERVE_x until pmem_resp=1, then return to IDLE at the next edge; minimum grant-to-grant spacing is 2 cycles.
REQ-009 if_mem_resp SHALL equal pmem_resp AND state==SERVE_IF; mem_resp SHALL equal pmem_resp AND state==SERVE_MEM (combinational, same cycle).
REQ-010 if_mem_rdata and mem_rdata SHALL both be pmem_rdata pass-through.
REQ-011 Requester dropping its request mid-transaction SHALL NOT abort the pmem transaction; it completes and the resp is still issued to that requester's port.
REQ-012 mem_read and mem_write both high SHALL be treated as a write.
REQ-013 Simultaneous IF and MEM requests in IDLE SHALL grant MEM (fixed priority), except as modified by REQ-017.
REQ-014 pmem_resp while in IDLE SHALL be ignored; no requester resp asserted.

Reset
REQ-015 rst=1 SHALL force IDLE, all pmem_* outputs 0, if_mem_resp=0, mem_resp=0, starvation counter 0, immediately (asynchronously).
REQ-016 Reset mid-transaction SHALL abandon the transaction; no resp issued for it after rst deasserts.

Configuration
REQ-017 With ARB_STARVE_GUARD_EN defined: a counter SHALL increment on each MEM grant made while if_memread=1, clear on every IF grant, saturate at STARVE_LIMIT; when equal to STARVE_LIMIT, a simultaneous conflict in IDLE SHALL grant IF.
REQ-018 Without ARB_STARVE_GUARD_EN: no counter logic; pure MEM priority per REQ-013; STARVE_LIMIT unused.

Structure
REQ-019 State enum (mem_arb_state_t) SHALL reside in lc3b_types alongside lc3b_word; no new constants outside it.
REQ-020 Single module, no sub-modules; optional counter inline under the macro.

Verification
REQ-021 IF-only read, addr 0x3000, pmem_resp after 3 cycles with rdata 0x1234 -> pmem_read high 3 cycles, if_mem_resp 1 cycle, if_mem_rdata 0x1234, mem_resp 0.
REQ-022 MEM write addr 0x4002, be 2'b01, wdata 0xABCD -> pmem_write=1, pmem_byte_enable 01, pmem_wdata 0xABCD held until resp; mem_resp pulses once.
REQ-023 IF and MEM request same cycle -> MEM served first, IF granted 2 cycles after MEM resp edge.
REQ-024 Macro on, STARVE_LIMIT=4, both requesting continuously -> grant order MEM×4, IF, MEM×4, IF.
REQ-025 Requester address changes mid-SERVE -> pmem_address unchanged; rst asserted mid-SERVE -> pmem_read drops same cycle, no resp after release.
